// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one internal alu between two valid/ready requesters.
// Optional macro ALU_ARB_STATS_EN adds per-requester saturating response counters cnt0/cnt1.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_z,
  output logic             rsp_l
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("alu_arbiter: WIDTH and CNT_W must be positive");
  end

  state_t           state_r;
  state_t           state_s;
  logic             last_id_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       f_r;
  logic             id_r;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_y_r;
  logic             rsp_z_r;
  logic             rsp_l_r;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             accept_s;
  logic             rsp_fire_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_z_s;
  logic             alu_l_s;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a (a_r),
    .b (b_r),
    .f (f_r),
    .y (alu_y_s),
    .z (alu_z_s),
    .l (alu_l_s)
  );

  assign rsp_fire_s = rsp_valid_r & rsp_ready;
  // Grants are suppressed while reset is asserted so nothing is accepted in the reset cycle.
  assign req0_ready = gnt0_s & rstn;
  assign req1_ready = gnt1_s & rstn;
  assign accept_s   = req0_ready | req1_ready;

  // Next-state and grant selection; on a tie the port that did not finish last wins.
  always_comb begin
    state_s = state_r;
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          if (last_id_r) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
          state_s = EXEC;
        end else if (req0_valid) begin
          gnt0_s  = 1'b1;
          state_s = EXEC;
        end else if (req1_valid) begin
          gnt1_s  = 1'b1;
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (rsp_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch for the granted request.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_r  <= '0;
      b_r  <= '0;
      f_r  <= 3'b000;
      id_r <= 1'b0;
    end else if (accept_s) begin
      a_r  <= gnt1_s ? req1_a : req0_a;
      b_r  <= gnt1_s ? req1_b : req0_b;
      f_r  <= gnt1_s ? req1_f : req0_f;
      id_r <= gnt1_s;
    end
  end

  // Response registers; contents stay put after the handshake, only valid drops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_y_r     <= '0;
      rsp_z_r     <= 1'b0;
      rsp_l_r     <= 1'b0;
      last_id_r   <= 1'b1;
    end else if (state_r == EXEC) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= id_r;
      rsp_y_r     <= alu_y_s;
      rsp_z_r     <= alu_z_s;
      rsp_l_r     <= alu_l_s;
    end else if (rsp_fire_s) begin
      rsp_valid_r <= 1'b0;
      last_id_r   <= rsp_id_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_y     = rsp_y_r;
  assign rsp_z     = rsp_z_r;
  assign rsp_l     = rsp_l_r;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // Completed-response counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else if (rsp_fire_s) begin
      if (!rsp_id_r && (cnt0_r != {CNT_W{1'b1}})) begin
        cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (rsp_id_r && (cnt1_r != {CNT_W{1'b1}})) begin
        cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;
`endif

endmodule

// Combinational ALU: add/sub/and/or/xor, reserved opcodes yield zero.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       f,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             l
);

  function automatic logic [WIDTH-1:0] alu_op(input logic [WIDTH-1:0] op_a,
                                              input logic [WIDTH-1:0] op_b,
                                              input logic [2:0]       op_f);
    logic [WIDTH-1:0] res;
    case (op_f)
      3'b000:  res = op_a + op_b;
      3'b001:  res = op_a - op_b;
      3'b010:  res = op_a & op_b;
      3'b011:  res = op_a | op_b;
      3'b100:  res = op_a ^ op_b;
      default: res = '0;
    endcase
    return res;
  endfunction

  assign y = alu_op(a, b, f);
  assign z = (y == '0);
  assign l = y[WIDTH-1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; inputs driven and outputs sampled on negedge.
module tb_alu_arbiter;

  logic        clk;
  logic        rstn;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_f;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_f;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_y;
  logic        rsp_z, rsp_l;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_f     (req0_f),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_f     (req1_f),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y),
    .rsp_z      (rsp_z),
    .rsp_l      (rsp_l)
`ifdef ALU_ARB_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One isolated operation from one port with rsp_ready high in RESP.
  task automatic single(input string tag, input logic port, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] f, input logic [31:0] ey,
                        input logic ez, input logic el);
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_f = f;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_f = f;
    end
    #1;
    chk({tag, "_rdy0"}, {31'd0, req0_ready}, {31'd0, ~port});
    chk({tag, "_rdy1"}, {31'd0, req1_ready}, {31'd0, port});
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_y"}, rsp_y, ey);
    chk({tag, "_z"}, {31'd0, rsp_z}, {31'd0, ez});
    chk({tag, "_l"}, {31'd0, rsp_l}, {31'd0, el});
    chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, port});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_f = 3'b000;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_f = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_y", rsp_y, 32'd0);
    req0_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    // Basic single-port operations and opcode coverage.
    single("t1_add", 1'b0, 32'd5, 32'd3, 3'b000, 32'd8, 1'b0, 1'b0);
    single("t2_sub", 1'b1, 32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE, 1'b0, 1'b1);
    single("t4_xor", 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b100, 32'd0, 1'b1, 1'b0);
    single("t4_f7", 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'b111, 32'd0, 1'b1, 1'b0);
    single("f5_zero", 1'b1, 32'h8000_0001, 32'h1234_5678, 3'b101, 32'd0, 1'b1, 1'b0);
    single("or", 1'b1, 32'h0000_00F0, 32'h8000_000F, 3'b011, 32'h8000_00FF, 1'b0, 1'b1);
    single("and", 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000, 1'b0, 1'b1);
    single("wrap_add", 1'b0, 32'hFFFF_FFFF, 32'd2, 3'b000, 32'd1, 1'b0, 1'b0);

    // Round robin from reset: both held valid, grants alternate 0,1,0,1.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_f = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd7;  req1_b = 32'd9; req1_f = 3'b010;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rdy0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_rdy1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      @(negedge clk);
      chk("rr_exec_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk);
      chk("rr_rdy_resp", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("rr_id", {31'd0, rsp_id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_y", rsp_y, (i % 2 == 1) ? 32'd1 : 32'd6);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

    // Backpressure in RESP with port 1 waiting.
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_f = 3'b000;
    #1;
    chk("bp_rdy0", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_f = 3'b001;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_y", rsp_y, 32'd101);
      chk("bp_id", {31'd0, rsp_id}, 32'd0);
      chk("bp_rdy1", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_grant1", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_r1_y", rsp_y, 32'd0);
    chk("bp_r1_z", {31'd0, rsp_z}, 32'd1);
    chk("bp_r1_id", {31'd0, rsp_id}, 32'd1);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Leave port 0 as last winner with a non-zero response, then reset mid-op.
    single("pre_rst", 1'b0, 32'd0, 32'd1, 3'b001, 32'hFFFF_FFFF, 1'b0, 1'b1);
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd9; req1_f = 3'b000;
    #1;
    chk("t6_rdy1", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_f = 3'b000;
    @(negedge clk);
    chk("t6_rst_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    chk("t6_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_y", rsp_y, 32'd0);
    chk("t6_zl_id", {29'd0, rsp_z, rsp_l, rsp_id}, 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("t6_cnt", {cnt0, cnt1}, 32'd0);
`endif
    rstn = 1'b1;
    #1;
    chk("t6_first0", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("t6_post_y", rsp_y, 32'd2);
    chk("t6_post_id", {31'd0, rsp_id}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
    chk("t6_cnt_after", {cnt0, cnt1}, {16'd1, 16'd0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
